// File: rtl/lfsr_seq_checker.sv
// Sequence checker for the 4-bit LFSR stage: predicts each sample, locks, counts
// mismatches, flags the stuck all-zero state and measures the sequence period.
module lfsr_seq_checker #(
    parameter int SYNC_LEN = 4,
    parameter int LOSS_LEN = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       data_in,
    input  logic             valid_in,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [4:0]       period,
    output logic             period_valid,
    output logic             zero_state
);

    localparam int MC_W = $clog2(SYNC_LEN + 1);
    localparam int ML_W = $clog2(LOSS_LEN + 1);
    localparam logic [MC_W-1:0] SYNC_LAST = MC_W'(SYNC_LEN - 1);
    localparam logic [ML_W-1:0] LOSS_LAST = ML_W'(LOSS_LEN - 1);
    localparam logic [4:0]      PC_MAX    = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOCKED
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [3:0]       r_pred,      w_pred_nxt;
    logic [3:0]       r_ref,       w_ref_nxt;
    logic [MC_W-1:0]  r_match_cnt, w_match_cnt_nxt;
    logic [ML_W-1:0]  r_miss_cnt,  w_miss_cnt_nxt;
    logic [4:0]       r_pc,        w_pc_nxt;
    logic             r_recap,     w_recap_nxt;
    logic             r_error,     w_error_nxt;
    logic [CNT_W-1:0] r_err_cnt,   w_err_cnt_nxt;
    logic [4:0]       r_period,    w_period_nxt;
    logic             r_pv,        w_pv_nxt;
    logic             r_zero,      w_zero_nxt;

    logic             w_nonzero;
    logic             w_hit;
    logic             w_recap_now;
    logic [4:0]       w_pc_inc;
    logic [CNT_W-1:0] w_cnt_inc;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[1] ^ s[0], s[3], s[2], s[1]};
    endfunction

    assign w_nonzero   = |data_in;
    assign w_hit       = (data_in == r_pred);
    // A clear arriving with the sample re-captures the reference on that same sample.
    assign w_recap_now = r_recap | clear;
    assign w_pc_inc    = (r_pc == PC_MAX) ? r_pc : r_pc + 5'd1;
    assign w_cnt_inc   = (&r_err_cnt) ? r_err_cnt : r_err_cnt + CNT_W'(1);

    // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt     = r_state;
        w_pred_nxt      = r_pred;
        w_ref_nxt       = r_ref;
        w_match_cnt_nxt = r_match_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_pc_nxt        = r_pc;
        w_recap_nxt     = r_recap;
        w_error_nxt     = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;
        w_period_nxt    = r_period;
        w_pv_nxt        = r_pv;
        w_zero_nxt      = r_zero;

        if (valid_in) begin
            w_zero_nxt = ~w_nonzero;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_nonzero) begin
                        w_pred_nxt      = lfsr_next(data_in);
                        w_match_cnt_nxt = '0;
                        w_state_nxt     = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    w_pred_nxt = lfsr_next(data_in);
                    if (w_hit && w_nonzero) begin
                        if (r_match_cnt == SYNC_LAST) begin
                            w_state_nxt     = ST_LOCKED;
                            w_match_cnt_nxt = '0;
                            w_miss_cnt_nxt  = '0;
                            w_ref_nxt       = data_in;
                            w_pc_nxt        = '0;
                            w_recap_nxt     = 1'b0;
                        end else begin
                            w_match_cnt_nxt = r_match_cnt + MC_W'(1);
                        end
                    end else begin
                        w_match_cnt_nxt = '0;
                        if (!w_nonzero) w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (w_hit) begin
                        w_pred_nxt     = lfsr_next(data_in);
                        w_miss_cnt_nxt = '0;
                        if (!w_recap_now && data_in == r_ref) begin
                            w_period_nxt = w_pc_inc;
                            w_pv_nxt     = 1'b1;
                            w_pc_nxt     = '0;
                        end else begin
                            w_pc_nxt = w_pc_inc;
                        end
                    end else begin
                        w_error_nxt   = 1'b1;
                        w_err_cnt_nxt = w_cnt_inc;
                        w_pc_nxt      = w_pc_inc;
                        if (r_miss_cnt == LOSS_LAST) begin
                            w_state_nxt     = ST_SYNC;
                            w_pred_nxt      = lfsr_next(data_in);
                            w_match_cnt_nxt = '0;
                            w_miss_cnt_nxt  = '0;
                        end else begin
                            // Assume the stream carried on underneath a glitch.
                            w_pred_nxt     = lfsr_next(r_pred);
                            w_miss_cnt_nxt = r_miss_cnt + ML_W'(1);
                        end
                    end
                    if (w_recap_now) begin
                        w_ref_nxt   = data_in;
                        w_pc_nxt    = '0;
                        w_recap_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        if (clear) begin
            w_err_cnt_nxt = '0;
            w_period_nxt  = '0;
            w_pv_nxt      = 1'b0;
            w_pc_nxt      = '0;
            if (!(valid_in && (r_state == ST_LOCKED || w_state_nxt == ST_LOCKED)))
                w_recap_nxt = 1'b1;
        end
    end

    // NOTE: reset is synchronous, so clk is the only event; state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pred      <= '0;
            r_ref       <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_pc        <= '0;
            r_recap     <= 1'b0;
            r_error     <= 1'b0;
            r_err_cnt   <= '0;
            r_period    <= '0;
            r_pv        <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_ref       <= w_ref_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
            r_pc        <= w_pc_nxt;
            r_recap     <= w_recap_nxt;
            r_error     <= w_error_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_period    <= w_period_nxt;
            r_pv        <= w_pv_nxt;
            r_zero      <= w_zero_nxt;
        end
    end

    assign locked       = (r_state == ST_LOCKED);
    assign error        = r_error;
    assign err_count    = r_err_cnt;
    assign period       = r_period;
    assign period_valid = r_pv;
    assign zero_state   = r_zero;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus a randomized stream checked
// against a model that walks the known 15-entry LFSR cycle.
module tb_lfsr_seq_checker;

    localparam int SYNC_LEN = 4;
    localparam int LOSS_LEN = 3;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       data_in = 4'd0;
    logic             valid_in = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic [4:0]       period;
    logic             period_valid;
    logic             zero_state;

    int n_checks = 0;
    int n_errors = 0;

    // The full LFSR cycle starting at 0001.
    logic [3:0] seq [15] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001,
                             4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010,
                             4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011};

    lfsr_seq_checker #(.SYNC_LEN(SYNC_LEN), .LOSS_LEN(LOSS_LEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .clear        (clear),
        .locked       (locked),
        .error        (error),
        .err_count    (err_count),
        .period       (period),
        .period_valid (period_valid),
        .zero_state   (zero_state)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = hunting for a start, 1 = confirming, 2 = locked.
    int m_mode, m_pred, m_streak, m_miss, m_ref, m_pc, m_errcnt, m_period;
    bit m_recap, m_pv, m_zero, m_error;

    function automatic int nxt(input int s);
        for (int i = 0; i < 15; i++)
            if (int'(seq[i]) == s) return int'(seq[(i + 1) % 15]);
        return 0;
    endfunction

    function automatic int sat(input int x, input int lim);
        return (x > lim) ? lim : x;
    endfunction

    task automatic model_step(input logic rst_n, input logic v, input logic [3:0] d, input logic c);
        int di;
        bit consumed;
        di = int'(d);
        consumed = 0;
        if (!rst_n) begin
            m_mode = 0; m_pred = 0; m_streak = 0; m_miss = 0; m_ref = 0; m_pc = 0;
            m_errcnt = 0; m_period = 0; m_recap = 0; m_pv = 0; m_zero = 0; m_error = 0;
            return;
        end
        m_error = 0;
        if (v) begin
            m_zero = (di == 0);
            if (m_mode == 0) begin
                if (di != 0) begin m_pred = nxt(di); m_streak = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (di == m_pred && di != 0) begin
                    m_streak++;
                    m_pred = nxt(di);
                    if (m_streak == SYNC_LEN) begin
                        m_mode = 2; m_ref = di; m_pc = 0; m_recap = 0; m_miss = 0; m_streak = 0;
                        consumed = 1;
                    end
                end else begin
                    m_pred = nxt(di); m_streak = 0;
                    if (di == 0) m_mode = 0;
                end
            end else begin
                consumed = 1;
                if (di == m_pred) begin
                    m_pred = nxt(di); m_miss = 0;
                    if (!(m_recap || c) && di == m_ref) begin
                        m_period = sat(m_pc + 1, 31); m_pv = 1; m_pc = 0;
                    end else begin
                        m_pc = sat(m_pc + 1, 31);
                    end
                end else begin
                    m_error = 1;
                    m_errcnt = sat(m_errcnt + 1, CNT_MAX);
                    m_pc = sat(m_pc + 1, 31);
                    m_miss++;
                    if (m_miss == LOSS_LEN) begin
                        m_mode = 1; m_pred = nxt(di); m_streak = 0; m_miss = 0;
                    end else begin
                        m_pred = nxt(m_pred);
                    end
                end
                if (m_recap || c) begin m_ref = di; m_pc = 0; m_recap = 0; end
            end
        end
        if (c) begin
            m_errcnt = 0; m_period = 0; m_pv = 0; m_pc = 0;
            if (!consumed) m_recap = 1;
        end
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic c);
        valid_in = v;
        data_in  = d;
        clear    = c;
        @(posedge clk);
        model_step(reset, v, d, c);
        #1;
        valid_in = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic lock_up();
        for (int i = 0; i < 5; i++) step(1'b1, seq[i], 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({locked, error, err_count, period, period_valid, zero_state} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got l=%0b e=%0b cnt=%0d per=%0d pv=%0b z=%0b required all 0",
                     locked, error, err_count, period, period_valid, zero_state);
        end
    endtask

    task automatic test_lock_period();
        bit err_seen;
        err_seen = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i], 1'b0);
            err_seen |= error;
            if (i == 3) begin
                n_checks++;
                if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_early: got %0b required 0", locked); end
            end
        end
        n_checks++;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL lock_point: got %0b required 1", locked); end
        for (int i = 5; i < 20; i++) begin
            step(1'b1, seq[i % 15], 1'b0);
            err_seen |= error;
            if (i == 18) begin
                n_checks++;
                if (period_valid !== 1'b0) begin n_errors++; $display("FAIL pv_early: got %0b required 0", period_valid); end
            end
        end
        n_checks++;
        if (period !== 5'd15 || period_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL period15: got per=%0d pv=%0b required 15/1", period, period_valid);
        end
        n_checks++;
        if (err_seen !== 1'b0) begin n_errors++; $display("FAIL lock_no_error: got error seen required none"); end
    endtask

    task automatic test_glitch();
        do_reset();
        lock_up();
        step(1'b1, seq[5], 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        n_checks++;
        if ({error, err_count, zero_state, locked} !== {1'b1, 8'd1, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL glitch: got e=%0b cnt=%0d z=%0b l=%0b required 1/1/1/1", error, err_count, zero_state, locked);
        end
        for (int i = 7; i < 10; i++) begin
            step(1'b1, seq[i], 1'b0);
            n_checks++;
            if ({error, err_count, zero_state, locked} !== {1'b0, 8'd1, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL glitch_resume: got e=%0b cnt=%0d z=%0b l=%0b required 0/1/0/1", error, err_count, zero_state, locked);
            end
        end
    endtask

    task automatic test_loss();
        do_reset();
        lock_up();
        step(1'b1, 4'b1111, 1'b0);
        n_checks++;
        if (error !== 1'b1 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL loss_first: got e=%0b l=%0b required 1/1", error, locked);
        end
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        n_checks++;
        if (err_count !== 8'd3 || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL loss_drop: got cnt=%0d l=%0b required 3/0", err_count, locked);
        end
        for (int i = 13; i < 16; i++) step(1'b1, seq[i % 15], 1'b0);
        n_checks++;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL relock_early: got %0b required 0", locked); end
        step(1'b1, seq[1], 1'b0);
        n_checks++;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL relock: got %0b required 1", locked); end
    endtask

    task automatic test_gaps();
        bit err_seen;
        err_seen = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, seq[i % 15], 1'b0);
            err_seen |= error;
            if (i == 3 || i == 4) begin
                n_checks++;
                if (locked !== (i == 4)) begin
                    n_errors++;
                    $display("FAIL gap_lock_%0d: got %0b required %0b", i, locked, i == 4);
                end
            end
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
                err_seen |= error;
            end
        end
        n_checks++;
        if (period !== 5'd15 || period_valid !== 1'b1 || err_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_period: got per=%0d pv=%0b err_seen=%0b required 15/1/0", period, period_valid, err_seen);
        end
    endtask

    task automatic test_stuck_sync();
        logic [3:0] restart [7] = '{4'b0001, 4'b1000, 4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0100};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0000, 1'b0);
            n_checks++;
            if ({locked, zero_state, err_count} !== {1'b0, 1'b1, 8'd0}) begin
                n_errors++;
                $display("FAIL stuck_zero: got l=%0b z=%0b cnt=%0d required 0/1/0", locked, zero_state, err_count);
            end
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b1, restart[i], 1'b0);
            if (i >= 5) begin
                n_checks++;
                if (locked !== (i == 6)) begin
                    n_errors++;
                    $display("FAIL sync_restart_%0d: got %0b required %0b", i, locked, i == 6);
                end
            end
        end
    endtask

    task automatic test_clear_reset();
        do_reset();
        lock_up();
        for (int i = 5; i < 20; i++) step(1'b1, seq[i % 15], 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, seq[6], 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, seq[8], 1'b0);
        n_checks++;
        if ({err_count, period, period_valid, locked} !== {8'd2, 5'd15, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL pre_clear: got cnt=%0d per=%0d pv=%0b l=%0b required 2/15/1/1", err_count, period, period_valid, locked);
        end
        step(1'b0, 4'b0000, 1'b1);
        n_checks++;
        if ({err_count, period, period_valid, locked} !== {8'd0, 5'd0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL clear: got cnt=%0d per=%0d pv=%0b l=%0b required 0/0/0/1", err_count, period, period_valid, locked);
        end
        for (int i = 9; i < 25; i++) begin
            step(1'b1, seq[i % 15], 1'b0);
            if (i == 23) begin
                n_checks++;
                if (period_valid !== 1'b0) begin n_errors++; $display("FAIL recap_early: got %0b required 0", period_valid); end
            end
        end
        n_checks++;
        if (period !== 5'd15 || period_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL recap_period: got per=%0d pv=%0b required 15/1", period, period_valid);
        end
        reset = 1'b0;
        step(1'b1, seq[10], 1'b1);
        reset = 1'b1;
        n_checks++;
        if ({locked, error, err_count, period, period_valid, zero_state} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: got l=%0b e=%0b cnt=%0d per=%0d pv=%0b z=%0b required all 0",
                     locked, error, err_count, period, period_valid, zero_state);
        end
        for (int i = 11; i < 15; i++) step(1'b1, seq[i], 1'b0);
        n_checks++;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL post_reset_idle: got %0b required 0", locked); end
        step(1'b1, seq[0], 1'b0);
        n_checks++;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL post_reset_lock: got %0b required 1", locked); end
    endtask

    task automatic test_saturation();
        int pos;
        do_reset();
        lock_up();
        pos = 5;
        for (int k = 0; k < 260; k++) begin
            step(1'b1, seq[pos] ^ 4'b0001, 1'b0);
            pos = (pos + 1) % 15;
            step(1'b1, seq[pos], 1'b0);
            pos = (pos + 1) % 15;
        end
        n_checks++;
        if (err_count !== 8'd255 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL err_saturate: got cnt=%0d l=%0b required 255/1", err_count, locked);
        end
        // Clear together with a zero sample: ref becomes 0000, which never recurs.
        step(1'b1, 4'b0000, 1'b1);
        pos = (pos + 1) % 15;
        n_checks++;
        if (err_count !== 8'd0 || error !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_with_valid: got cnt=%0d e=%0b required 0/1", err_count, error);
        end
        for (int k = 0; k < 40; k++) begin
            step(1'b1, seq[pos], 1'b0);
            pos = (pos + 1) % 15;
        end
        n_checks++;
        if ({period, period_valid, locked} !== {5'd0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL pc_saturate: got per=%0d pv=%0b l=%0b required 0/0/1", period, period_valid, locked);
        end
    endtask

    task automatic test_random();
        int pos;
        int roll;
        logic v, c;
        logic [3:0] d;
        do_reset();
        pos = $urandom_range(0, 14);
        for (int n = 0; n < 4000; n++) begin
            v = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 299) != 0);
            roll = $urandom_range(0, 19);
            if (roll == 0)      d = 4'($urandom_range(0, 15));
            else if (roll == 1) d = 4'b0000;
            else begin
                if (roll == 2) pos = $urandom_range(0, 14);
                d = seq[pos];
            end
            if (v) pos = (pos + 1) % 15;
            step(v, d, c);
            reset = 1'b1;
            n_checks++;
            if ({locked, error, err_count, period, period_valid, zero_state} !==
                {m_mode == 2, m_error, CNT_W'(m_errcnt), 5'(m_period), m_pv, m_zero}) begin
                n_errors++;
                $display("FAIL random_%0d: got l=%0b e=%0b cnt=%0d per=%0d pv=%0b z=%0b required l=%0b e=%0b cnt=%0d per=%0d pv=%0b z=%0b",
                         n, locked, error, err_count, period, period_valid, zero_state,
                         m_mode == 2, m_error, m_errcnt, m_period, m_pv, m_zero);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_period();
        test_glitch();
        test_loss();
        test_gaps();
        test_stuck_sync();
        test_clear_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
